// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci term sequencer.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the index can reach 2^in_w-1 without wrapping.
  function automatic int fib_idx_w(input int in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/fib_add.sv
// Carry-out adder used for each Fibonacci step.
module fib_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign sum   = full[W-1:0];
  assign carry = full[W];

endmodule

// File: rtl/fib_seq.sv
// Computes term n of a seeded Fibonacci sequence, with a sticky carry flag.
// Optional FIB_SEQ_STREAM_EN adds a valid/ready stream of terms 1..n.
//   state | meaning
//   IDLE  | waiting for go after reset
//   CALC  | stepping the x/y pair until term n is reached
//   DONE  | result/overflow held, go may start a new run
module fib_seq
  import fib_pkg::*;
#(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [INPUT_WIDTH-1:0]  n,
  input  logic [OUTPUT_WIDTH-1:0] seed0,
  input  logic [OUTPUT_WIDTH-1:0] seed1,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    done,
  output logic                    busy
`ifdef FIB_SEQ_STREAM_EN
  ,
  output logic                    term_valid,
  output logic [OUTPUT_WIDTH-1:0] term_data,
  input  logic                    term_ready
`endif
);

  localparam int IW = fib_idx_w(INPUT_WIDTH);

  state_t                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  n_q, n_d;
  logic [IW-1:0]           i_q, i_d;
  logic [OUTPUT_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [OUTPUT_WIDTH-1:0] result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [IW-1:0]           n_ext;
  logic [OUTPUT_WIDTH-1:0] sum;
  logic                    carry;
  logic                    step, finish;
`ifdef FIB_SEQ_STREAM_EN
  logic                    tv_q, tv_d;
  logic [OUTPUT_WIDTH-1:0] td_q, td_d;
  logic [IW-1:0]           t_q, t_d;
`endif

  assign n_ext = {1'b0, n_q};

  fib_add #(.W(OUTPUT_WIDTH)) u_add (
    .a    (x_q),
    .b    (y_q),
    .sum  (sum),
    .carry(carry)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    busy_d   = busy_q;
    step     = 1'b0;
    finish   = 1'b0;
`ifdef FIB_SEQ_STREAM_EN
    tv_d     = tv_q;
    td_d     = td_q;
    t_d      = t_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = CALC;
          n_d     = n;
          i_d     = IW'(2);
          x_d     = seed0;
          y_d     = seed1;
          ovf_d   = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef FIB_SEQ_STREAM_EN
          tv_d    = (n != '0);
          td_d    = seed0;
          t_d     = IW'(1);
`endif
        end
      end
      CALC: begin
`ifdef FIB_SEQ_STREAM_EN
        // t_q is the index of the term on the stream; the pair only advances once it is taken.
        if (!(tv_q && !term_ready)) begin
          if (t_q >= n_ext) begin
            finish = 1'b1;
            tv_d   = 1'b0;
          end else begin
            tv_d = 1'b1;
            t_d  = t_q + IW'(1);
            if (t_q == IW'(1)) begin
              td_d = y_q;
            end else begin
              step = 1'b1;
              td_d = sum;
            end
          end
        end
`else
        if (i_q >= n_ext) finish = 1'b1;
        else              step   = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (step) begin
      y_d   = sum;
      x_d   = y_q;
      i_d   = i_q + IW'(1);
      ovf_d = ovf_q | carry;
    end
    if (finish) begin
      state_d = DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      if (n_q == '0)                      result_d = '0;
      else if (n_q == INPUT_WIDTH'(1))    result_d = x_q;
      else                                result_d = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      i_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef FIB_SEQ_STREAM_EN
      tv_q     <= 1'b0;
      td_q     <= '0;
      t_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      i_q      <= i_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef FIB_SEQ_STREAM_EN
      tv_q     <= tv_d;
      td_q     <= td_d;
      t_q      <= t_d;
`endif
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = busy_q;
`ifdef FIB_SEQ_STREAM_EN
  assign term_valid = tv_q;
  assign term_data  = td_q;
`endif

endmodule

// File: tb/tb_fib_seq.sv
// Directed bench for fib_seq: a 32-bit and an 8-bit instance with hand-computed terms.
module tb_fib_seq;

  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go32 = 1'b0;
  logic          go8 = 1'b0;
  logic [IW-1:0] n = '0;
  logic [31:0]   seed0 = '0;
  logic [31:0]   seed1 = '0;
  logic [31:0]   res32;
  logic          ovf32, done32, busy32;
  logic [7:0]    res8;
  logic          ovf8, done8, busy8;
  int            n_checks = 0;
  int            n_fail = 0;
`ifdef FIB_SEQ_STREAM_EN
  logic          tr32 = 1'b1;
  logic          tv32, tv8;
  logic [31:0]   td32;
  logic [7:0]    td8;
`endif

  always #5 clk = ~clk;

  fib_seq #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .go(go32), .n(n), .seed0(seed0), .seed1(seed1),
    .result(res32), .overflow(ovf32), .done(done32), .busy(busy32)
`ifdef FIB_SEQ_STREAM_EN
    , .term_valid(tv32), .term_data(td32), .term_ready(tr32)
`endif
  );

  fib_seq #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .n(n), .seed0(seed0[7:0]), .seed1(seed1[7:0]),
    .result(res8), .overflow(ovf8), .done(done8), .busy(busy8)
`ifdef FIB_SEQ_STREAM_EN
    , .term_valid(tv8), .term_data(td8), .term_ready(1'b1)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int nn);
`ifdef FIB_SEQ_STREAM_EN
    return (nn == 0) ? 1 : nn;
`else
    return (nn <= 2) ? 1 : nn - 1;
`endif
  endfunction

  task automatic run(input bit sel, input int nn, input logic [31:0] s0, input logic [31:0] s1,
                     input logic [31:0] exp_res, input logic exp_ovf, input bit mid_go);
    int cyc;
    n     = nn[IW-1:0];
    seed0 = s0;
    seed1 = s1;
    if (sel) go8 = 1'b1;
    else     go32 = 1'b1;
    tick();
    go8  = 1'b0;
    go32 = 1'b0;
    check_val($sformatf("busy_after_go_n%0d", nn), 64'(sel ? busy8 : busy32), 64'd1);
    check_val($sformatf("done_clr_after_go_n%0d", nn), 64'(sel ? done8 : done32), 64'd0);
    cyc = 0;
    while (!(sel ? done8 : done32) && cyc < 200) begin
      if (mid_go && cyc == 1) begin
        go32  = 1'b1;
        n     = 6'd20;
        seed0 = 32'd9;
        seed1 = 32'd9;
      end else begin
        go32 = 1'b0;
      end
      tick();
      cyc++;
    end
    go32 = 1'b0;
    check_val($sformatf("latency_n%0d", nn), 64'(cyc), 64'(exp_lat(nn)));
    check_val($sformatf("result_n%0d", nn), 64'(sel ? {24'd0, res8} : res32), 64'(exp_res));
    check_val($sformatf("overflow_n%0d", nn), 64'(sel ? ovf8 : ovf32), 64'(exp_ovf));
    check_val($sformatf("busy_at_done_n%0d", nn), 64'(sel ? busy8 : busy32), 64'd0);
    repeat (3) tick();
    check_val($sformatf("result_hold_n%0d", nn), 64'(sel ? {24'd0, res8} : res32), 64'(exp_res));
    check_val($sformatf("done_hold_n%0d", nn), 64'(sel ? done8 : done32), 64'd1);
  endtask

  initial begin
    bit seen;
    // go held high through the first edge while still in reset
    go32 = 1'b1;
    go8  = 1'b1;
    n    = 6'd5;
    tick();
    check_val("reset_result", 64'(res32), 64'd0);
    check_val("reset_done", 64'(done32), 64'd0);
    check_val("reset_busy", 64'(busy32), 64'd0);
    check_val("reset_busy8", 64'(busy8), 64'd0);
    rst  = 1'b1;
    go32 = 1'b0;
    go8  = 1'b0;
    tick();
    check_val("go_in_reset_ignored", 64'(busy32), 64'd0);

    run(1'b0, 10, 32'd0, 32'd1, 32'd34, 1'b0, 1'b0);
    run(1'b0, 2, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0);
    run(1'b0, 1, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
    run(1'b0, 0, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
    run(1'b0, 63, 32'd0, 32'd1, 32'd2585377753, 1'b1, 1'b0);

    run(1'b1, 14, 32'd0, 32'd1, 32'd233, 1'b0, 1'b0);
    run(1'b1, 15, 32'd0, 32'd1, 32'd121, 1'b1, 1'b0);
    run(1'b1, 3, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0);

    run(1'b0, 5, 32'd2, 32'd1, 32'd7, 1'b0, 1'b1);

    // reset pulse in the middle of a long run
    n     = 6'd30;
    seed0 = 32'd0;
    seed1 = 32'd1;
    go32  = 1'b1;
    tick();
    go32 = 1'b0;
    repeat (4) tick();
    check_val("busy_before_rst", 64'(busy32), 64'd1);
    rst = 1'b0;
    #1;
    check_val("rst_result", 64'(res32), 64'd0);
    check_val("rst_busy", 64'(busy32), 64'd0);
    check_val("rst_done", 64'(done32), 64'd0);
    check_val("rst_overflow", 64'(ovf32), 64'd0);
    go32 = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b1;
    go32 = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done32 || busy32) seen = 1'b1;
    end
    check_val("no_activity_after_rst", 64'(seen), 64'd0);

`ifdef FIB_SEQ_STREAM_EN
    begin
      logic [31:0] exp_terms [6];
      int hs;
      int cyc;
      exp_terms = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5};
      n     = 6'd6;
      seed0 = 32'd0;
      seed1 = 32'd1;
      go32  = 1'b1;
      tick();
      go32 = 1'b0;
      hs   = 0;
      cyc  = 0;
      while (!done32 && cyc < 100) begin
        tr32 = cyc[0];
        if (tv32 && tr32) begin
          if (hs < 6) check_val($sformatf("stream_term%0d", hs), 64'(td32), 64'(exp_terms[hs]));
          hs++;
        end
        tick();
        cyc++;
      end
      tr32 = 1'b1;
      check_val("stream_handshakes", 64'(hs), 64'd6);
      check_val("stream_done", 64'(done32), 64'd1);
      check_val("stream_result", 64'(res32), 64'd5);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_seq.md
FIB_SEQ -- requirements
Module: fib_seq

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 6: bit width of n.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32: bit width of seeds, result and adder.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port go  input  1  start request, active high.
REQ-006 SHALL have port n  input  INPUT_WIDTH  index of the term to compute (1-based).
REQ-007 SHALL have port seed0  input  OUTPUT_WIDTH  term 1 value.
REQ-008 SHALL have port seed1  input  OUTPUT_WIDTH  term 2 value.
REQ-009 SHALL have port result  output  OUTPUT_WIDTH  computed term, valid while done=1.
REQ-010 SHALL have port overflow  output  1  sticky carry-out flag for the current run, valid while done=1.
REQ-011 SHALL have port done  output  1  result valid.
REQ-012 SHALL have port busy  output  1  computation in progress; go ignored.

Function
REQ-013 SHALL define term(1)=seed0, term(2)=seed1, term(k)=term(k-1)+term(k-2) mod 2^OUTPUT_WIDTH; n=0 SHALL yield result 0.
REQ-014 SHALL implement states IDLE, CALC, DONE: IDLE/DONE --go--> CALC; CALC --(i>=n_r)--> DONE; else CALC.
REQ-015 SHALL accept go only in IDLE or DONE, capturing n, seed0 and seed1 into registers on that edge; later input changes SHALL have no effect on the run.
REQ-016 SHALL ignore go while busy=1 (no restart, no recapture).
REQ-017 SHALL on the accepting edge set busy=1, clear done and clear overflow, and load i=2, x=seed0, y=seed1.
REQ-018 SHALL in CALC with i<n_r compute y<=x+y, x<=y, i<=i+1 and OR the adder carry-out into overflow, once per cycle.
REQ-019 SHALL, in CALC with i>=n_r, load result (0 if n_r=0, x if n_r=1, else y), set done=1 and busy=0, and enter DONE.
REQ-020 SHALL produce done max(1, n-1) cycles after the accepting edge (streaming disabled).
REQ-021 SHALL hold result, overflow and done stable in DONE until the next accepted go.
REQ-022 SHALL never assert done and busy together.
REQ-023 SHALL use an OUTPUT_WIDTH+1-bit sum; bit OUTPUT_WIDTH is the carry and the low bits are the stored term.
REQ-024 SHALL support n = 2^INPUT_WIDTH-1 without the counter i wrapping (i is INPUT_WIDTH+1 bits).

Reset
REQ-025 SHALL, while rst=0, immediately force state=IDLE, result=0, overflow=0, done=0, busy=0, i/x/y=0, regardless of clk or go.
REQ-026 SHALL, after reset mid-run, discard the run and produce no done until a new go.
REQ-027 SHALL ignore go sampled on the first edge while rst is still 0.

Configuration
REQ-028 SHALL, with FIB_SEQ_STREAM_EN defined, add ports term_valid (out), term_data (out, OUTPUT_WIDTH), term_ready (in), and present terms 1..n in order, each held until term_valid&&term_ready.
REQ-029 SHALL, with FIB_SEQ_STREAM_EN, stall CALC (no state or flag update) while term_valid=1 and term_ready=0; done SHALL rise only after the last term handshake.
REQ-030 SHALL, without FIB_SEQ_STREAM_EN, omit the stream ports and meet the REQ-020 latency exactly.

Structure
REQ-031 SHALL place state_t (IDLE, CALC, DONE) and the term-index width helper in package fib_pkg.
REQ-032 SHALL implement the carry-out adder as sub-module fib_add (OUTPUT_WIDTH operands, sum and carry outputs).

Verification
REQ-033 SHALL cover seed0=0, seed1=1, n=10 -> result=34, overflow=0, done exactly 9 cycles after go.
REQ-034 SHALL cover n=0, 1, 2 with seeds 0/1 -> results 0, 0, 1, each with done 1 cycle after go.
REQ-035 SHALL cover OUTPUT_WIDTH=8, seeds 0/1: n=14 -> 233 with overflow=0; n=15 -> 121 with overflow=1; then n=3 -> 1 with overflow=0.
REQ-036 SHALL cover seeds 2/1, n=5 -> 7; go pulsed with n=20 mid-run -> run unaffected, result still 7.
REQ-037 SHALL cover rst=0 for 1 cycle mid-run at n=30 -> outputs all 0 at once, no done afterwards until a new go.
REQ-038 SHALL cover FIB_SEQ_STREAM_EN, n=6, term_ready low on alternate cycles -> terms 0,1,1,2,3,5 in order, result=5, done after the sixth handshake.
